// File: rtl/neander_mem_arbiter.sv
// neander_mem_arbiter
// -------------------
// Two-master arbiter in front of a single-port synchronous RAM (1-cycle read
// latency). The CPU port and an external loader/debug port (EXT) share the
// RAM. Every access takes exactly three cycles: IDLE (grant) -> ACCESS (RAM
// clocks the access) -> RESP (read data captured, ack pulsed). All outputs
// are registered.
//
// Handshake (both requester ports): req is a level. It is sampled only in
// IDLE; addr/we/wdata are captured on the granting edge and may change
// afterwards. ack pulses for exactly one cycle when the access is complete.
// rdata is updated together with ack on reads only. A req still high on the
// edge that ends the ack cycle is taken as a new request.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   CPU request inputs
//   cpu_ack/cpu_rdata       CPU completion pulse / read data
//   ext_req/we/addr/wdata   EXT request inputs
//   ext_ack/ext_rdata       EXT completion pulse / read data
//   mem_en/we/addr/wdata    RAM control outputs
//   mem_rdata               RAM read data (valid the cycle after the en edge)
//   owner                   current grant: 00 none, 01 CPU, 10 EXT
//   dbg_state               FSM state (00 IDLE, 01 ACCESS, 10 RESP)
//
// Configuration macro:
//   NEANDER_ARB_RR_EN  defined  : ties resolved round-robin (CPU wins the
//                                 first tie after reset)
//                      undefined: fixed priority, CPU always wins ties

module neander_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_EXT  = 2'b10;

  state_e              state_q,     state_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                ext_ack_q,   ext_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic [1:0]          owner_q,     owner_d;
  // mem_we drops after ACCESS, so the read/write kind of the in-flight
  // access is kept separately for the RESP decision.
  logic                acc_we_q,    acc_we_d;
`ifdef NEANDER_ARB_RR_EN
  // 1 = EXT was granted last, 0 = CPU was granted last.
  logic                last_ext_q,  last_ext_d;
`endif

  logic                pick_cpu;

  always_comb begin
`ifdef NEANDER_ARB_RR_EN
    pick_cpu = cpu_req & (~ext_req | last_ext_q);
`else
    pick_cpu = cpu_req;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    owner_d     = owner_q;
    acc_we_d    = acc_we_q;
`ifdef NEANDER_ARB_RR_EN
    last_ext_d  = last_ext_q;
`endif

    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (cpu_req || ext_req) begin
          mem_en_d = 1'b1;
          state_d  = S_ACCESS;
          if (pick_cpu) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
            acc_we_d    = cpu_we;
            owner_d     = OWN_CPU;
          end else begin
            mem_addr_d  = ext_addr;
            mem_wdata_d = ext_wdata;
            mem_we_d    = ext_we;
            acc_we_d    = ext_we;
            owner_d     = OWN_EXT;
          end
`ifdef NEANDER_ARB_RR_EN
          last_ext_d = ~pick_cpu;
`endif
        end
      end

      S_ACCESS: begin
        // The RAM performs the access on this edge.
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = S_RESP;
      end

      S_RESP: begin
        if (owner_q == OWN_CPU) begin
          cpu_ack_d = 1'b1;
          if (!acc_we_q) cpu_rdata_d = mem_rdata;
        end else if (owner_q == OWN_EXT) begin
          ext_ack_d = 1'b1;
          if (!acc_we_q) ext_rdata_d = mem_rdata;
        end
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end

      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        owner_d  = OWN_NONE;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      owner_q     <= OWN_NONE;
      acc_we_q    <= 1'b0;
`ifdef NEANDER_ARB_RR_EN
      last_ext_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      owner_q     <= owner_d;
      acc_we_q    <= acc_we_d;
`ifdef NEANDER_ARB_RR_EN
      last_ext_q  <= last_ext_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Testbench for neander_mem_arbiter: a behavioural 1-cycle synchronous RAM,
// directed scenario tasks, and an expected-data queue filled when requests
// are driven and drained when acks appear.
module tb_neander_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ext_req, ext_we, ext_ack;
  logic [7:0] ext_addr, ext_wdata, ext_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] owner, dbg_state;

  int n_cmp;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] ram[256];
  logic [7:0] ref_mem[256];
  logic [7:0] cpu_rdata_exp;
  logic [7:0] ext_rdata_exp;

  neander_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Both acks high together is never allowed.
  always @(negedge clk) begin
    if (rst_n && (cpu_ack || ext_ack)) begin
      n_cmp++;
      if (cpu_ack && ext_ack) begin
        n_fail++;
        $display("FAIL ack_exclusive: cpu_ack=%b ext_ack=%b want not both", cpu_ack, ext_ack);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rdata_exp = 8'h00;
    ext_rdata_exp = 8'h00;
  endtask

  task automatic wait_any_ack(input int budget, output int cycles,
                              output logic c, output logic e);
    cycles = 0; c = 1'b0; e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles = i + 1;
      if (cpu_ack || ext_ack) begin
        c = cpu_ack; e = ext_ack;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, ext_ack, cpu_rdata, ext_rdata, owner}
        !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b we=%b a=%h d=%h ca=%b ea=%b cr=%h er=%h own=%b want all 0",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, ext_ack, cpu_rdata, ext_rdata, owner);
    end
    rst_n = 1'b1;
    cpu_rdata_exp = 8'h00;
    ext_rdata_exp = 8'h00;
  endtask

  task automatic test_cpu_read();
    logic [7:0] exp;
    ram[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    exp_q.push_back(ref_mem[8'h10]);
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, owner} !== {1'b1, 1'b0, 8'h10, 2'b01}) begin
      n_fail++;
      $display("FAIL cpu_read_grant: got en=%b we=%b addr=%h own=%b want 1 0 10 01",
               mem_en, mem_we, mem_addr, owner);
    end
    cpu_addr = 8'h55;  // must not disturb the in-flight read
    @(negedge clk);
    n_cmp++;
    if ({mem_en, owner, cpu_ack} !== {1'b0, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_read_access: got en=%b own=%b ack=%b want 0 01 0", mem_en, owner, cpu_ack);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    n_cmp++;
    if ({cpu_ack, owner, cpu_rdata} !== {1'b1, 2'b00, exp}) begin
      n_fail++;
      $display("FAIL cpu_read_resp: got ack=%b own=%b rdata=%h want 1 00 %h", cpu_ack, owner, cpu_rdata, exp);
    end
    cpu_rdata_exp = exp;
    n_cmp++;
    if ({ext_ack, ext_rdata} !== {1'b0, ext_rdata_exp}) begin
      n_fail++;
      $display("FAIL cpu_read_loser: got ext_ack=%b ext_rdata=%h want 0 %h", ext_ack, ext_rdata, ext_rdata_exp);
    end
    cpu_req = 0;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_ack_pulse: got %b want 0", cpu_ack);
    end
  endtask

  task automatic test_ext_write_cpu_read();
    int cyc; logic c, e; logic [7:0] exp;
    ext_we = 1; ext_addr = 8'h80; ext_wdata = 8'hC3; ext_req = 1;
    ref_mem[8'h80] = 8'hC3;
    wait_any_ack(6, cyc, c, e);
    n_cmp++;
    if ({cyc, c, e, ext_rdata} !== {32'd3, 1'b0, 1'b1, ext_rdata_exp}) begin
      n_fail++;
      $display("FAIL ext_write: got cyc=%0d cack=%b eack=%b rdata=%h want 3 0 1 %h",
               cyc, c, e, ext_rdata, ext_rdata_exp);
    end
    ext_req = 0; ext_we = 0;
    @(negedge clk);
    cpu_we = 0; cpu_addr = 8'h80; cpu_req = 1;
    exp_q.push_back(ref_mem[8'h80]);
    wait_any_ack(6, cyc, c, e);
    exp = exp_q.pop_front();
    n_cmp++;
    if ({cyc, c, e, cpu_rdata} !== {32'd3, 1'b1, 1'b0, exp}) begin
      n_fail++;
      $display("FAIL cpu_read_after_write: got cyc=%0d cack=%b eack=%b rdata=%h want 3 1 0 %h",
               cyc, c, e, cpu_rdata, exp);
    end
    cpu_rdata_exp = exp;
    cpu_req = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; logic c, e; logic [7:0] exp;
    for (int a = 0; a < 3; a++) begin
      ram[a] = 8'($urandom_range(0, 255));
      ref_mem[a] = ram[a];
    end
    cpu_we = 0; cpu_addr = 8'h00; cpu_req = 1;
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(ref_mem[a]);
      wait_any_ack(6, cyc, c, e);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if ({cyc, c, cpu_rdata} !== {32'd3, 1'b1, exp}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got cyc=%0d ack=%b rdata=%h want 3 1 %h", a, cyc, c, cpu_rdata, exp);
      end
      cpu_rdata_exp = exp;
      if (a == 2) cpu_req = 0;
      else        cpu_addr = 8'(a + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int cyc; logic c, e; logic [7:0] exp;
    logic want_ext[4];
`ifdef NEANDER_ARB_RR_EN
    want_ext[0] = 0; want_ext[1] = 1; want_ext[2] = 0; want_ext[3] = 1;
`else
    want_ext[0] = 0; want_ext[1] = 0; want_ext[2] = 0; want_ext[3] = 0;
`endif
    do_reset();
    ram[8'h20] = 8'($urandom_range(0, 255)); ref_mem[8'h20] = ram[8'h20];
    ram[8'h30] = 8'($urandom_range(0, 255)); ref_mem[8'h30] = ram[8'h30];
    cpu_we = 0; cpu_addr = 8'h20; ext_we = 0; ext_addr = 8'h30;
    cpu_req = 1; ext_req = 1;
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(want_ext[g] ? ref_mem[8'h30] : ref_mem[8'h20]);
      wait_any_ack(6, cyc, c, e);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if ({cyc, c, e} !== {32'd3, ~want_ext[g], want_ext[g]}) begin
        n_fail++;
        $display("FAIL tie_grant[%0d]: got cyc=%0d cack=%b eack=%b want 3 %b %b",
                 g, cyc, c, e, ~want_ext[g], want_ext[g]);
      end
      n_cmp++;
      if (want_ext[g]) begin
        if ({ext_rdata, cpu_rdata} !== {exp, cpu_rdata_exp}) begin
          n_fail++;
          $display("FAIL tie_data[%0d]: got ext=%h cpu=%h want %h %h", g, ext_rdata, cpu_rdata, exp, cpu_rdata_exp);
        end
        ext_rdata_exp = exp;
      end else begin
        if ({cpu_rdata, ext_rdata} !== {exp, ext_rdata_exp}) begin
          n_fail++;
          $display("FAIL tie_data[%0d]: got cpu=%h ext=%h want %h %h", g, cpu_rdata, ext_rdata, exp, ext_rdata_exp);
        end
        cpu_rdata_exp = exp;
      end
    end
    cpu_req = 0; ext_req = 0;
    @(negedge clk);
  endtask

  task automatic test_holdoff();
    int ci, ei; logic [7:0] exp;
    ci = -1; ei = -1;
    ram[8'h40] = 8'($urandom_range(0, 255)); ref_mem[8'h40] = ram[8'h40];
    ram[8'h41] = 8'($urandom_range(0, 255)); ref_mem[8'h41] = ram[8'h41];
    cpu_we = 0; cpu_addr = 8'h40; cpu_req = 1;
    exp_q.push_back(ref_mem[8'h40]);
    @(negedge clk);  // DUT now in ACCESS for the CPU
    ext_we = 0; ext_addr = 8'h41; ext_req = 1;
    exp_q.push_back(ref_mem[8'h41]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        ci = i;
        exp = exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata !== exp) begin
          n_fail++;
          $display("FAIL holdoff_cpu_data: got %h want %h", cpu_rdata, exp);
        end
        cpu_rdata_exp = exp;
        cpu_req = 0;
      end
      if (ext_ack) begin
        ei = i;
        exp = exp_q.pop_front();
        n_cmp++;
        if (ext_rdata !== exp) begin
          n_fail++;
          $display("FAIL holdoff_ext_data: got %h want %h", ext_rdata, exp);
        end
        ext_rdata_exp = exp;
        ext_req = 0;
      end
      if (i == 2) begin
        n_cmp++;
        if (owner !== 2'b10) begin
          n_fail++;
          $display("FAIL holdoff_owner: got %b want 10", owner);
        end
      end
    end
    n_cmp++;
    if ({ci, ei} !== {32'sd1, 32'sd4}) begin
      n_fail++;
      $display("FAIL holdoff_timing: got cpu_ack@%0d ext_ack@%0d want 1 4", ci, ei);
    end
    exp_q.delete();
    cpu_req = 0; ext_req = 0;
  endtask

  task automatic test_reset_mid_op();
    int acks;
    acks = 0;
    cpu_we = 1; cpu_addr = 8'h90; cpu_wdata = 8'h77; cpu_req = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, owner} !== {1'b1, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL midop_pre: got en=%b we=%b own=%b want 1 1 01", mem_en, mem_we, owner);
    end
    #2 rst_n = 1'b0;
    cpu_req = 0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, cpu_ack, ext_ack, owner} !== 13'd0) begin
      n_fail++;
      $display("FAIL midop_async: got en=%b we=%b addr=%h cack=%b eack=%b own=%b want all 0",
               mem_en, mem_we, mem_addr, cpu_ack, ext_ack, owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rdata_exp = 8'h00; ext_rdata_exp = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ack || ext_ack || mem_en) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL midop_no_ack: got %0d active cycles want 0", acks);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    for (int a = 0; a < 256; a++) begin
      ram[a] = 8'($urandom_range(0, 255));
      ref_mem[a] = ram[a];
    end
    mem_rdata = 8'h00;
    test_reset();
    @(negedge clk);
    test_cpu_read();
    test_ext_write_cpu_read();
    test_back_to_back();
    test_tie();
    test_holdoff();
    @(negedge clk);
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/neander_mem_arbiter.md
NEANDER_MEM_ARBITER -- requirements
Module: neander_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width (256-byte Neander space).
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have these ports: clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cpu_req / cpu_we  in  1 / 1  CPU access request (level) / write select.
REQ-006 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data.
REQ-007 cpu_ack / cpu_rdata  out  1 / DATA_W  CPU completion pulse / read data.
REQ-008 ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata: external loader/debug port, same widths and meaning as the CPU port.
REQ-009 mem_en / mem_we  out  1 / 1  single-port RAM enable / write enable.
REQ-010 mem_addr / mem_wdata  out  ADDR_W / DATA_W  RAM address / write data.
REQ-011 mem_rdata  in  DATA_W  RAM read data, valid the cycle after the mem_en edge (1-cycle synchronous read).
REQ-012 owner  out  2  current grant: 00 none, 01 CPU, 10 EXT; 11 never driven.

Function
REQ-013 All outputs SHALL be registered; states IDLE, ACCESS, RESP.
REQ-014 IDLE: on an edge with any req high, latch winner's addr/wdata/we into mem_*, set mem_en=1, set owner, go to ACCESS; no req: remain IDLE, mem_en=0.
REQ-015 ACCESS: on next edge clear mem_en and mem_we, go to RESP (RAM performs access at this edge).
REQ-016 RESP: on next edge, for a read, load mem_rdata into winner's rdata; pulse winner's ack for exactly one cycle; clear owner; go to IDLE.
REQ-017 Latency: req sampled at edge k -> mem_en high k..k+1 -> ack high k+2..k+3; one access per 3 cycles maximum throughput.
REQ-018 On writes, the requester's rdata SHALL hold its previous value; the loser's ack and rdata SHALL never change.
REQ-019 req still high on the edge ending the ack cycle SHALL be treated as a new request (back-to-back); requesters drop req during the ack cycle otherwise.
REQ-020 Changes to a requester's addr/wdata/we after its request is sampled SHALL NOT affect the in-flight access.
REQ-021 Requests arriving while in ACCESS or RESP SHALL be held off (no ack) until evaluated in IDLE.
REQ-022 cpu_ack and ext_ack SHALL never be high in the same cycle; mem_en SHALL never be high more than one cycle per grant except as given in REQ-017.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, ext_ack=0, cpu_rdata=0, ext_rdata=0, owner=00, last-grant register = EXT.
REQ-024 Reset mid-access SHALL discard the pending transaction with no ack; requesters re-request after release.
REQ-025 First evaluation SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro NEANDER_ARB_RR_EN defined: simultaneous requests in IDLE granted round-robin to the port not granted last (last-grant updated on each grant; after reset CPU wins first tie).
REQ-027 NEANDER_ARB_RR_EN undefined: fixed priority, CPU always wins ties; last-grant register absent; single-requester behaviour identical.

Verification
REQ-028 CPU read: mem[0x10]=0x5A, cpu_req=1 we=0 addr=0x10 at edge k -> mem_en=1 addr=0x10 at k, cpu_ack=1 and cpu_rdata=0x5A at k+2, owner 01 then 00.
REQ-029 EXT write then CPU read: ext writes 0xC3 to 0x80 -> ext_ack at k+2, ext_rdata unchanged; CPU read 0x80 -> 0xC3.
REQ-030 Tie, RR_EN defined: both req held high continuously -> grants CPU, EXT, CPU, EXT; acks alternate every 3 cycles; undefined -> only cpu_ack pulses.
REQ-031 Back-to-back: cpu_req held high 9 cycles, addrs 0x00,0x01,0x02 -> three acks spaced 3 cycles, data matching memory.
REQ-032 Reset mid-op: rst_n low during ACCESS -> mem_en, acks, owner 0 immediately; no ack after release until new req.
REQ-033 Hold-off: ext_req raised while CPU in ACCESS -> ext granted at first IDLE edge, ext_ack 2 cycles later, never overlapping cpu_ack.
